// File: rtl/l1_l2_miss_arbiter.sv
// l1_l2_miss_arbiter: round-robin block-miss arbiter between the L1I/L1D miss ports and the L2 port.
module l1_l2_miss_arbiter #(
  parameter int BLOCK_WORDS = 4,
  parameter int BW_ADD      = 24
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              l1i_req_i,
  input  logic              l1i_rw_i,
  input  logic [BW_ADD-1:0] l1i_add_i,
  input  logic [31:0]       l1i_data_i,
  output logic              l1i_take_o,
  output logic [31:0]       l1i_data_o,
  output logic              l1i_valid_o,
  output logic              l1i_done_o,
  input  logic              l1d_req_i,
  input  logic              l1d_rw_i,
  input  logic [BW_ADD-1:0] l1d_add_i,
  input  logic [31:0]       l1d_data_i,
  output logic              l1d_take_o,
  output logic [31:0]       l1d_data_o,
  output logic              l1d_valid_o,
  output logic              l1d_done_o,
  output logic              l2_req_o,
  output logic              l2_rw_o,
  output logic [BW_ADD-1:0] l2_add_o,
  output logic [31:0]       l2_data_o,
  input  logic              l2_write_ready_i,
  input  logic [31:0]       l2_data_i,
  input  logic              l2_valid_i,
  input  logic              l2_done_i,
  output logic              err_o
);
  localparam int CW = $clog2(BLOCK_WORDS) + 1;
  localparam logic [CW-1:0] FULL = CW'(BLOCK_WORDS);
  localparam logic [1:0] IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2;
  logic [1:0]        r_state;
  logic              r_sel, r_rw, r_last, r_err, r_i_valid, r_d_valid;
  logic [BW_ADD-1:0] r_add;
  logic [CW-1:0]     r_cnt;
  logic [31:0]       r_i_data, r_d_data;
  logic              w_xfer, w_room, w_take, w_fill, w_gnt_d;
  logic [CW-1:0]     w_cnt_nxt;
  assign w_xfer    = r_state == XFER;
  assign w_room    = r_cnt < FULL;
  assign w_take    = w_xfer & r_rw & w_room & l2_write_ready_i;
  assign w_fill    = w_xfer & ~r_rw & w_room & l2_valid_i;
  assign w_cnt_nxt = r_cnt + CW'(w_take | w_fill);
  // r_last = 1 means D was served last, so I wins a tie
  assign w_gnt_d   = l1d_req_i & (~l1i_req_i | ~r_last);
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state   <= IDLE;
      r_sel     <= 1'b0;
      r_rw      <= 1'b0;
      r_last    <= 1'b1;
      r_err     <= 1'b0;
      r_add     <= '0;
      r_cnt     <= '0;
      r_i_data  <= '0;
      r_d_data  <= '0;
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
    end else begin
      r_i_valid <= w_fill & ~r_sel;
      r_d_valid <= w_fill & r_sel;
      if (w_fill & ~r_sel) r_i_data <= l2_data_i;
      if (w_fill & r_sel) r_d_data <= l2_data_i;
      if (r_state == IDLE && (l1i_req_i | l1d_req_i)) begin
        r_state <= XFER;
        r_sel   <= w_gnt_d;
        r_rw    <= w_gnt_d ? l1d_rw_i : l1i_rw_i;
        r_add   <= w_gnt_d ? l1d_add_i : l1i_add_i;
      end
      if (w_xfer) begin
        r_cnt <= w_cnt_nxt;
        if (l2_done_i) r_state <= DONE;
      end
      if (r_state == DONE) begin
        r_state <= IDLE;
        r_last  <= r_sel;
        r_cnt   <= '0;
      end
      if ((w_xfer & l2_done_i & (w_cnt_nxt != FULL)) | (w_xfer & ~r_rw & l2_valid_i & ~w_room))
        r_err <= 1'b1;
    end
  end
  assign l2_req_o    = w_xfer;
  assign l2_rw_o     = r_rw;
  assign l2_add_o    = r_add;
  assign l2_data_o   = (w_xfer & r_rw) ? (r_sel ? l1d_data_i : l1i_data_i) : 32'd0;
  assign l1i_take_o  = w_take & ~r_sel;
  assign l1d_take_o  = w_take & r_sel;
  assign l1i_data_o  = r_i_data;
  assign l1d_data_o  = r_d_data;
  assign l1i_valid_o = r_i_valid;
  assign l1d_valid_o = r_d_valid;
  assign l1i_done_o  = (r_state == DONE) & ~r_sel;
  assign l1d_done_o  = (r_state == DONE) & r_sel;
  assign err_o       = r_err;
endmodule

// File: tb/tb_l1_l2_miss_arbiter.sv
// tb_l1_l2_miss_arbiter: directed scenario bench for the L1/L2 miss arbiter.
module tb_l1_l2_miss_arbiter;
  logic        clock_i = 1'b0, reset_i;
  logic        l1i_req_i, l1i_rw_i, l1d_req_i, l1d_rw_i;
  logic [23:0] l1i_add_i, l1d_add_i, l2_add_o;
  logic [31:0] l1i_data_i, l1d_data_i, l1i_data_o, l1d_data_o, l2_data_o, l2_data_i;
  logic        l1i_take_o, l1i_valid_o, l1i_done_o, l1d_take_o, l1d_valid_o, l1d_done_o;
  logic        l2_req_o, l2_rw_o, l2_write_ready_i, l2_valid_i, l2_done_i, err_o;
  int errs = 0, checks = 0;

  l1_l2_miss_arbiter dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .l1i_req_i(l1i_req_i), .l1i_rw_i(l1i_rw_i), .l1i_add_i(l1i_add_i), .l1i_data_i(l1i_data_i),
    .l1i_take_o(l1i_take_o), .l1i_data_o(l1i_data_o), .l1i_valid_o(l1i_valid_o), .l1i_done_o(l1i_done_o),
    .l1d_req_i(l1d_req_i), .l1d_rw_i(l1d_rw_i), .l1d_add_i(l1d_add_i), .l1d_data_i(l1d_data_i),
    .l1d_take_o(l1d_take_o), .l1d_data_o(l1d_data_o), .l1d_valid_o(l1d_valid_o), .l1d_done_o(l1d_done_o),
    .l2_req_o(l2_req_o), .l2_rw_o(l2_rw_o), .l2_add_o(l2_add_o), .l2_data_o(l2_data_o),
    .l2_write_ready_i(l2_write_ready_i), .l2_data_i(l2_data_i), .l2_valid_i(l2_valid_i),
    .l2_done_i(l2_done_i), .err_o(err_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic tick;
    @(posedge clock_i);
    #1;
  endtask

  task automatic clear_in;
    l1i_req_i = 0; l1i_rw_i = 0; l1i_add_i = '0; l1i_data_i = '0;
    l1d_req_i = 0; l1d_rw_i = 0; l1d_add_i = '0; l1d_data_i = '0;
    l2_write_ready_i = 0; l2_data_i = '0; l2_valid_i = 0; l2_done_i = 0;
  endtask

  task automatic do_reset;
    clear_in;
    reset_i = 1;
    tick;
    tick;
    reset_i = 0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if ({l2_req_o, l2_rw_o, l1i_take_o, l1d_take_o, l1i_valid_o, l1d_valid_o, l1i_done_o, l1d_done_o, err_o} !== 9'd0) begin
      errs++;
      $display("FAIL reset_flags got=%b exp=0", {l2_req_o, l2_rw_o, l1i_take_o, l1d_take_o, l1i_valid_o, l1d_valid_o, l1i_done_o, l1d_done_o, err_o});
    end
    checks++;
    if ({l2_add_o, l2_data_o, l1i_data_o, l1d_data_o} !== 120'd0) begin
      errs++;
      $display("FAIL reset_data got=%h/%h/%h/%h exp=0", l2_add_o, l2_data_o, l1i_data_o, l1d_data_o);
    end
  endtask

  task automatic test_read;
    l1i_req_i = 1; l1i_rw_i = 0; l1i_add_i = 24'h000040;
    tick;
    checks++;
    if ({l2_req_o, l2_rw_o, l2_add_o} !== {1'b1, 1'b0, 24'h000040}) begin
      errs++;
      $display("FAIL read_l2_req got=%b/%b/%h exp=1/0/000040", l2_req_o, l2_rw_o, l2_add_o);
    end
    for (int k = 0; k < 4; k++) begin
      l2_valid_i = 1; l2_data_i = 32'(32'hA0 + k);
      tick;
      checks++;
      if ({l1i_valid_o, l1i_data_o, l1i_done_o} !== {1'b1, 32'(32'hA0 + k), 1'b0}) begin
        errs++;
        $display("FAIL read_word%0d got=%b/%h/%b exp=1/%h/0", k, l1i_valid_o, l1i_data_o, l1i_done_o, 32'(32'hA0 + k));
      end
      checks++;
      if ({l1d_valid_o, l1d_data_o, l1d_done_o} !== 34'd0) begin
        errs++;
        $display("FAIL read_d_quiet%0d got=%b/%h/%b exp=0", k, l1d_valid_o, l1d_data_o, l1d_done_o);
      end
    end
    l2_valid_i = 0; l2_done_i = 1;
    tick;
    checks++;
    if ({l1i_done_o, l1d_done_o, l2_req_o, l1i_valid_o, err_o} !== 5'b10000) begin
      errs++;
      $display("FAIL read_done got=%b exp=10000", {l1i_done_o, l1d_done_o, l2_req_o, l1i_valid_o, err_o});
    end
    l2_done_i = 0; l1i_req_i = 0;
    tick;
    checks++;
    if ({l1i_done_o, l2_req_o, err_o} !== 3'b000) begin
      errs++;
      $display("FAIL read_after got=%b exp=000", {l1i_done_o, l2_req_o, err_o});
    end
  endtask

  task automatic test_round_robin;
    do_reset;
    l1i_req_i = 1; l1i_add_i = 24'h000080;
    l1d_req_i = 1; l1d_add_i = 24'h0000C0;
    tick;
    checks++;
    if (l2_add_o !== 24'h000080) begin
      errs++;
      $display("FAIL rr_first got=%h exp=000080", l2_add_o);
    end
    for (int k = 0; k < 4; k++) begin
      l2_valid_i = 1; l2_data_i = 32'(32'hB0 + k); l2_done_i = (k == 3);
      tick;
    end
    checks++;
    if ({l1i_done_o, l1d_done_o, err_o} !== 3'b100) begin
      errs++;
      $display("FAIL rr_i_done got=%b exp=100", {l1i_done_o, l1d_done_o, err_o});
    end
    l2_valid_i = 0; l2_done_i = 0; l1i_req_i = 0;
    tick;
    tick;
    checks++;
    if ({l2_req_o, l2_add_o} !== {1'b1, 24'h0000C0}) begin
      errs++;
      $display("FAIL rr_second got=%b/%h exp=1/0000C0", l2_req_o, l2_add_o);
    end
    for (int k = 0; k < 4; k++) begin
      l2_valid_i = 1; l2_data_i = 32'(32'hC0 + k); l2_done_i = (k == 3);
      tick;
    end
    checks++;
    if ({l1d_done_o, l1i_done_o, l1d_valid_o, l1d_data_o, err_o} !== {3'b101, 32'hC3, 1'b0}) begin
      errs++;
      $display("FAIL rr_d_done got=%b%b%b/%h/%b exp=101/c3/0", l1d_done_o, l1i_done_o, l1d_valid_o, l1d_data_o, err_o);
    end
    l2_valid_i = 0; l2_done_i = 0; l1i_req_i = 1;
    tick;
    tick;
    checks++;
    if ({l2_req_o, l2_add_o} !== {1'b1, 24'h000080}) begin
      errs++;
      $display("FAIL rr_third got=%b/%h exp=1/000080", l2_req_o, l2_add_o);
    end
  endtask

  task automatic test_write;
    int taken = 0, ntake = 0;
    do_reset;
    l1d_req_i = 1; l1d_rw_i = 1; l1d_add_i = 24'h000100;
    tick;
    checks++;
    if ({l2_req_o, l2_rw_o, l2_add_o} !== {1'b1, 1'b1, 24'h000100}) begin
      errs++;
      $display("FAIL wr_l2_req got=%b/%b/%h exp=1/1/000100", l2_req_o, l2_rw_o, l2_add_o);
    end
    for (int k = 0; k < 8; k++) begin
      bit exp_take;
      exp_take = (k % 2 == 0);
      l2_write_ready_i = exp_take; l1d_data_i = 32'(32'hD0 + taken);
      #1;
      checks++;
      if ({l1d_take_o, l1i_take_o} !== {exp_take, 1'b0}) begin
        errs++;
        $display("FAIL wr_take%0d got=%b%b exp=%b0", k, l1d_take_o, l1i_take_o, exp_take);
      end
      if (exp_take) begin
        checks++;
        if (l2_data_o !== 32'(32'hD0 + taken)) begin
          errs++;
          $display("FAIL wr_data%0d got=%h exp=%h", k, l2_data_o, 32'(32'hD0 + taken));
        end
      end
      if (l1d_take_o) ntake++;
      tick;
      if (exp_take) taken++;
    end
    checks++;
    if (ntake !== 4) begin
      errs++;
      $display("FAIL wr_take_count got=%0d exp=4", ntake);
    end
    l2_write_ready_i = 1;
    #1;
    checks++;
    if (l1d_take_o !== 1'b0) begin
      errs++;
      $display("FAIL wr_full_take got=%b exp=0", l1d_take_o);
    end
    tick;
    l2_write_ready_i = 0; l2_done_i = 1;
    tick;
    checks++;
    if ({l1d_done_o, l1i_done_o, l2_req_o, err_o} !== 4'b1000) begin
      errs++;
      $display("FAIL wr_done got=%b exp=1000", {l1d_done_o, l1i_done_o, l2_req_o, err_o});
    end
    l2_done_i = 0; l1d_req_i = 0;
    tick;
  endtask

  task automatic test_short_done;
    do_reset;
    l1i_req_i = 1; l1i_add_i = 24'h000200;
    tick;
    for (int k = 0; k < 2; k++) begin
      l2_valid_i = 1; l2_data_i = 32'(32'h50 + k);
      tick;
    end
    l2_valid_i = 0; l2_done_i = 1;
    tick;
    checks++;
    if ({l1i_done_o, err_o} !== 2'b11) begin
      errs++;
      $display("FAIL short_done got=%b exp=11", {l1i_done_o, err_o});
    end
    l2_done_i = 0; l1i_req_i = 0; l1d_req_i = 1; l1d_add_i = 24'h000300;
    tick;
    tick;
    checks++;
    if ({l2_req_o, l2_add_o} !== {1'b1, 24'h000300}) begin
      errs++;
      $display("FAIL short_next got=%b/%h exp=1/000300", l2_req_o, l2_add_o);
    end
    for (int k = 0; k < 4; k++) begin
      l2_valid_i = 1; l2_data_i = 32'(32'h60 + k); l2_done_i = (k == 3);
      tick;
    end
    checks++;
    if ({l1d_done_o, l1d_data_o, err_o} !== {1'b1, 32'h63, 1'b1}) begin
      errs++;
      $display("FAIL short_sticky got=%b/%h/%b exp=1/63/1", l1d_done_o, l1d_data_o, err_o);
    end
    clear_in;
    tick;
  endtask

  task automatic test_extra_valid;
    do_reset;
    l1i_req_i = 1; l1i_add_i = 24'h000240;
    tick;
    for (int k = 0; k < 4; k++) begin
      l2_valid_i = 1; l2_data_i = 32'(32'h70 + k);
      tick;
    end
    checks++;
    if (err_o !== 1'b0) begin
      errs++;
      $display("FAIL extra_pre_err got=%b exp=0", err_o);
    end
    l2_data_i = 32'hEE;
    tick;
    checks++;
    if ({l1i_valid_o, l1i_data_o, err_o} !== {1'b0, 32'h73, 1'b1}) begin
      errs++;
      $display("FAIL extra_valid got=%b/%h/%b exp=0/73/1", l1i_valid_o, l1i_data_o, err_o);
    end
    l2_valid_i = 0; l2_done_i = 1;
    tick;
    checks++;
    if (l1i_done_o !== 1'b1) begin
      errs++;
      $display("FAIL extra_done got=%b exp=1", l1i_done_o);
    end
    l2_done_i = 0; l1i_req_i = 0;
    tick;
  endtask

  task automatic test_reset_mid;
    l1d_req_i = 1; l1d_rw_i = 1; l1d_add_i = 24'h000400; l1d_data_i = 32'h11;
    tick;
    l2_write_ready_i = 1;
    tick;
    tick;
    reset_i = 1;
    tick;
    checks++;
    if ({l2_req_o, l1i_take_o, l1d_take_o, err_o} !== 4'b0000) begin
      errs++;
      $display("FAIL rst_mid got=%b exp=0000", {l2_req_o, l1i_take_o, l1d_take_o, err_o});
    end
    reset_i = 0; l2_write_ready_i = 0;
    l1i_req_i = 1; l1i_rw_i = 0; l1i_add_i = 24'h000500;
    tick;
    checks++;
    if ({l2_req_o, l2_rw_o, l2_add_o} !== {1'b1, 1'b0, 24'h000500}) begin
      errs++;
      $display("FAIL rst_regrant got=%b/%b/%h exp=1/0/000500", l2_req_o, l2_rw_o, l2_add_o);
    end
    do_reset;
  endtask

  initial begin
    test_reset;
    test_read;
    test_round_robin;
    test_write;
    test_short_done;
    test_extra_valid;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/l1_l2_miss_arbiter.md
Name: l1_l2_miss_arbiter

Overview:
- Sits between the L1 instruction cache and L1 data cache miss ports and the single L1-side port of the combined L2 cache.
- Arbitrates block-granular miss traffic from the two L1s, round-robin, one transaction at a time.
- Streams write-back words from the L1 to L2 and fill words from L2 back to the L1.
- Signals per-requester completion and flags protocol errors to the exception bus.

Parameters:
BLOCK_WORDS, 4, 32-bit words per cache block; power of two, at least 2.
BW_ADD, 24, word-address width on both sides.

Ports:
clock_i  in  1  single system clock, rising edge.
reset_i  in  1  synchronous, active-high reset.
l1i_req_i / l1d_req_i  in  1  miss request; held high until the matching done pulse.
l1i_rw_i / l1d_rw_i  in  1  1 = write-back, 0 = fill read; stable while req is high.
l1i_add_i / l1d_add_i  in  BW_ADD  block-aligned word address; stable while req is high.
l1i_data_i / l1d_data_i  in  32  write word; must be valid in any cycle its take strobe is high.
l1i_take_o / l1d_take_o  out  1  write word consumed this cycle; requester advances to the next word.
l1i_data_o / l1d_data_o  out  32  fill word, registered.
l1i_valid_o / l1d_valid_o  out  1  fill word valid, registered.
l1i_done_o / l1d_done_o  out  1  one-cycle transaction-complete pulse.
l2_req_o  out  1  request to L2, held for the whole transaction.
l2_rw_o  out  1  latched rw.
l2_add_o  out  BW_ADD  latched address.
l2_data_o  out  32  write word, combinational from the granted requester.
l2_write_ready_i  in  1  L2 accepts l2_data_o this cycle.
l2_data_i  in  32  fill word.
l2_valid_i  in  1  fill word valid.
l2_done_i  in  1  L2 transaction complete.
err_o  out  1  sticky protocol error.

Behaviour:
- Reset state: all outputs 0; state IDLE; word counter 0; last_grant = D, so I wins the first tie.
- IDLE:
  - Only one request high: grant it.
  - Both high: grant the requester that is not last_grant.
  - On grant: latch sel, rw and add; go to XFER. l2_req_o/rw/add are registered and assert in the first XFER cycle.
- XFER, write (rw = 1):
  - take_sel = l2_write_ready_i while count < BLOCK_WORDS; the take strobe is combinational.
  - l2_data_o = data_i of sel.
  - Each accepted word increments count.
  - l2_write_ready_i while count == BLOCK_WORDS: ignored, no take.
- XFER, read (rw = 0):
  - Each l2_valid_i with count < BLOCK_WORDS registers l2_data_i onto sel data_o, sets sel valid_o next cycle, and increments count.
  - Extra valids: dropped and set err_o.
  - The non-selected requester's data/valid outputs stay 0.
- Completion:
  - l2_done_i with count == BLOCK_WORDS: go to DONE.
  - l2_done_i with count < BLOCK_WORDS: set err_o and go to DONE anyway.
  - l2_done_i and the final word arriving in the same cycle: treated as count == BLOCK_WORDS, no error.
- DONE (one cycle):
  - l2_req_o = 0; the matching done_o pulses high; last_grant = sel; count = 0.
  - Requests are not sampled this cycle. Next state IDLE, so a requester still high re-arbitrates from IDLE with round-robin applied.
- Latency: the fill word reaches the L1 one cycle after l2_valid_i. The minimum transaction is grant (1) + BLOCK_WORDS + done (1) cycles.
- Request dropped mid-transaction: the transaction still completes to L2, and done still pulses.
- err_o stays set until reset.
- reset_i mid-transaction: back to the reset state next edge; l2_req_o drops. L2 is reset by the same signal.
- Counter width: clog2(BLOCK_WORDS)+1 bits; it never wraps.

Test Plan:
- Only l1i_req_i, read, add=0x000040, L2 returns 4 valids 0xA0..0xA3 then done → l2_req_o=1 with add 0x000040; l1i_valid_o high 4 cycles with 0xA0..0xA3; l1i_done_o pulses once; l1d outputs stay 0.
- Both requests asserted in the same cycle after reset → I granted first; after I's done, D granted; then both again → I granted (alternation).
- l1d write, add=0x000100, l2_write_ready_i high on alternate cycles → l1d_take_o mirrors ready exactly 4 times; l2_data_o matches l1d_data_i each take; done after l2_done_i.
- l2_done_i after only 2 read words → err_o=1 and stays 1; l1i_done_o still pulses; next request is still served normally.
- Fifth l2_valid_i before done → not forwarded (l1i_valid_o stays 0), err_o=1.
- reset_i asserted mid-write at count=2 → next cycle l2_req_o=0, take strobes 0, err_o=0; a new request is granted from the I-priority state.
